vga_vram_arbiter: RTL

- Single-port video RAM (VRAM) arbiter for the VGA subsystem.
- Two requesters share one synchronous RAM port:
  - the display line-fetch path, which feeds scanout driven by the horizontal/vertical counters;
  - the CPU, which reads and writes the framebuffer.
- Priority follows the blanking signal from the timing generator:
  - active video: display first;
  - blanking: CPU first.
- Read data is routed back to the requester that issued the read.

---
 rtl/vga_vram_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display scanout vs. CPU, blanking-aware priority.
// Optional CPU starvation guard enabled by defining VRAM_STARVE_GUARD_EN.
module vga_vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Blank,
    input  logic              Disp_Req,
    input  logic [ADDR_W-1:0] Disp_Addr,
    output logic              Disp_Gnt,
    output logic [DATA_W-1:0] Disp_Rdata,
    output logic              Disp_Valid,
    input  logic              Cpu_Req,
    input  logic              Cpu_We,
    input  logic [ADDR_W-1:0] Cpu_Addr,
    input  logic [DATA_W-1:0] Cpu_Wdata,
    output logic              Cpu_Gnt,
    output logic [DATA_W-1:0] Cpu_Rdata,
    output logic              Cpu_Valid,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_We,
    output logic [DATA_W-1:0] Mem_Wdata,
    input  logic [DATA_W-1:0] Mem_Rdata
);

    typedef enum logic [1:0] {
        TAG_IDLE,
        TAG_DISP,
        TAG_CPU_RD,
        TAG_CPU_WR
    } tag_e;

    logic              force_cpu;
    logic              cpu_win;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    tag_e              tag1_q, tag1_d;
    tag_e              tag2_q, tag2_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_valid_q, cpu_valid_d;

`ifdef VRAM_STARVE_GUARD_EN
    localparam int CW = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_WAIT = CW'(CPU_MAX_WAIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign force_cpu = (cnt_q == MAX_WAIT);

    always_comb begin
        cnt_d = cnt_q;
        if (!Cpu_Req || Cpu_Gnt) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    // CPU wins whenever the display is idle, we're blanking, or it has starved.
    assign cpu_win  = Cpu_Req & (~Disp_Req | In_Blank | force_cpu);
    assign Cpu_Gnt  = cpu_win;
    assign Disp_Gnt = Disp_Req & ~cpu_win;

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        tag1_d      = TAG_IDLE;
        if (Cpu_Req && Cpu_Gnt) begin
            mem_addr_d  = Cpu_Addr;
            mem_wdata_d = Cpu_Wdata;
            mem_we_d    = Cpu_We;
            tag1_d      = Cpu_We ? TAG_CPU_WR : TAG_CPU_RD;
        end else if (Disp_Req && Disp_Gnt) begin
            mem_addr_d = Disp_Addr;
            tag1_d     = TAG_DISP;
        end
        tag2_d = tag1_q;

        // tag2 marks the command whose RAM data is on Mem_Rdata now.
        disp_valid_d = (tag2_q == TAG_DISP);
        cpu_valid_d  = (tag2_q == TAG_CPU_RD);
        disp_rdata_d = disp_valid_d ? Mem_Rdata : disp_rdata_q;
        cpu_rdata_d  = cpu_valid_d ? Mem_Rdata : cpu_rdata_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            tag1_q       <= TAG_IDLE;
            tag2_q       <= TAG_IDLE;
            disp_rdata_q <= '0;
            disp_valid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_valid_q  <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            disp_rdata_q <= disp_rdata_d;
            disp_valid_q <= disp_valid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_valid_q  <= cpu_valid_d;
        end
    end

    assign Mem_Addr   = mem_addr_q;
    assign Mem_We     = mem_we_q;
    assign Mem_Wdata  = mem_wdata_q;
    assign Disp_Rdata = disp_rdata_q;
    assign Disp_Valid = disp_valid_q;
    assign Cpu_Rdata  = cpu_rdata_q;
    assign Cpu_Valid  = cpu_valid_q;

endmodule
